signal_phase_sequencer: RTL and testbench
=========================================

Name: signal_phase_sequencer

Overview:
- Downstream consumer of the green-time adaptation stage.
- Takes the four adapted green times (TGn/TGe/TGs/TGw) and runs the N→E→S→W signal rotation: GREEN, YELLOW, ALL_RED per road.
- Drives per-road lamp outputs.
- Feeds next_road back to the adaptation stage so it can compute the upcoming road's green time while the current phase runs.

Parameters:
- YELLOW_T, 3, yellow duration in ticks (≥1)
- ALL_RED_T, 1, all-red clearance in ticks (≥1)
- MIN_GREEN, 5, lower clamp on latched green time (≥1)
- MAX_GREEN, 60, upper clamp on latched green time (≤255, ≥MIN_GREEN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle time-base strobe (1 s); timers advance only when tick=1
- TGn, TGe, TGs, TGw  in  8 each  adapted green times, unsigned ticks
- next_road  out  2  road to be served after current (0=N,1=E,2=S,3=W)
- current_road  out  2  road currently owning the phase
- light_n, light_e, light_s, light_w  out  3 each  one-hot lamp {R,Y,G}: 100=red, 010=yellow, 001=green
- remaining  out  8  ticks left in current state
- phase_done  out  1  one-cycle pulse on each entry to GREEN

Behaviour:
- States: GREEN, YELLOW, ALL_RED (2-bit encoding).
- Reset (reset=0, async): state=ALL_RED, current_road=3, next_road=0, remaining=ALL_RED_T, all lights=100, phase_done=0.
- Countdown: on a clock edge with tick=1 and remaining>1, remaining decrements by 1. With tick=0, everything holds.
- Transitions occur on a clock edge with tick=1 and remaining==1:
  - GREEN→YELLOW: remaining=YELLOW_T.
  - YELLOW→ALL_RED: remaining=ALL_RED_T.
  - ALL_RED→GREEN:
    - current_road=next_road; next_road=(next_road+1) mod 4.
    - remaining = clamp(TG[next_road sampled that edge], MIN_GREEN, MAX_GREEN).
    - phase_done=1 for exactly that following cycle.
- Green latch: TG inputs are sampled only at the ALL_RED→GREEN edge. Input changes during a phase have no effect until the next GREEN entry.
- Clamp: 8-bit unsigned compare. TG<MIN_GREEN → MIN_GREEN (covers TG=0); TG>MAX_GREEN → MAX_GREEN.
- Lights are registered and change on the same edge as the state:
  - current_road: GREEN→001, YELLOW→010, ALL_RED→100.
  - All other roads are 100 at all times.
  - Never more than one non-red lamp.
- next_road wraps 3→0; current_road wraps identically.
- remaining never reaches 0 (all loaded values ≥1).
- Reset asserted mid-phase: outputs go to reset values immediately, without waiting for clk; rotation restarts at N.
- Latency: first green (north) begins ALL_RED_T ticks after reset release.

Optional Feature:
EMERGENCY_PREEMPT_EN
- Defined: adds inputs emerg_req (1) and emerg_road (2).
  - emerg_req=1 sampled in GREEN with current_road≠emerg_road: go to YELLOW on the next clock edge without waiting for tick; remaining=YELLOW_T.
  - emerg_req=1 sampled in YELLOW or ALL_RED: next_road is overridden to emerg_road; the ALL_RED→GREEN transition enters emerg_road.
  - While in GREEN on emerg_road with emerg_req=1: remaining is frozen.
  - Release of emerg_req: normal countdown resumes; rotation continues from emerg_road+1.
- Undefined: ports absent, pure fixed rotation; behaviour identical to the macro being defined with emerg_req tied 0.

Test Plan:
- Reset, tick every cycle, TGn=10 → lights all red, current_road=3, next_road=0, remaining=1; after 1 tick: light_n=001, current_road=0, next_road=1, remaining=10, phase_done pulses once.
- TGn=10, TGe=20 → north green 10 ticks, yellow 3, all-red 1; east green at tick 15 with remaining=20; next_road=2.
- Clamp: TGe=0 → east green lasts 5 ticks; TGs=200 → south green lasts 60 ticks.
- tick strobed once per 4 clocks, TGn=6 → remaining changes only on tick cycles; north green spans 24 clocks.
- Reset pulsed low mid-YELLOW on east → light_e=100 immediately; state ALL_RED, current_road=3, remaining=1; next green is north.
- With EMERGENCY_PREEMPT_EN: emerg_req=1, emerg_road=2 during north green (remaining=7) → light_n=010 next clock; after all-red, light_s=001 held while req=1; release → remaining counts down; next_road=3.

Source files
------------

// File: rtl/signal_phase_sequencer.sv
// signal_phase_sequencer: four-way N->E->S->W signal rotation.
// Each road goes GREEN -> YELLOW -> ALL_RED. The green time for a road is latched
// (and clamped) from the adaptation stage on entry to GREEN. next_road is fed back
// so the adaptation stage can prepare the upcoming road's green time.
// Optional build macro: EMERGENCY_PREEMPT_EN adds emerg_req/emerg_road pre-emption.
module signal_phase_sequencer #(
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALL_RED_T = 1,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg_req,
  input  logic [1:0] emerg_road,
`endif
  output logic [1:0] next_road,
  output logic [1:0] current_road,
  output logic [2:0] light_n,
  output logic [2:0] light_e,
  output logic [2:0] light_s,
  output logic [2:0] light_w,
  output logic [7:0] remaining,
  output logic       phase_done
);

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StAllRed = 2'd2
  } state_e;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  localparam logic [7:0] YellowLoad = 8'(YELLOW_T);
  localparam logic [7:0] AllRedLoad = 8'(ALL_RED_T);
  localparam logic [7:0] MinGreen   = 8'(MIN_GREEN);
  localparam logic [7:0] MaxGreen   = 8'(MAX_GREEN);

  // Pre-emption request as seen by the core; constant zero when the feature is absent.
  logic       emerg_act;
  logic [1:0] emerg_sel;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_act = emerg_req;
  assign emerg_sel = emerg_road;
`else
  assign emerg_act = 1'b0;
  assign emerg_sel = 2'd0;
`endif

  state_e          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      nxt_q, nxt_d;
  logic [7:0]      rem_q, rem_d;
  logic            phase_done_q, phase_done_d;
  logic [3:0][2:0] lights_q, lights_d;

  // Road that the coming ALL_RED->GREEN edge would enter, including any override.
  logic [1:0] nxt_eff;
  logic [7:0] tg_sel;

  function automatic logic [7:0] clamp_green(input logic [7:0] tg);
    if (tg < MinGreen) begin
      return MinGreen;
    end else if (tg > MaxGreen) begin
      return MaxGreen;
    end
    return tg;
  endfunction

  // Select the green-time input for the road about to be entered.
  always_comb begin
    nxt_eff = nxt_q;
    if (emerg_act && (state_q != StGreen)) begin
      nxt_eff = emerg_sel;
    end
    unique case (nxt_eff)
      2'd0:    tg_sel = TGn;
      2'd1:    tg_sel = TGe;
      2'd2:    tg_sel = TGs;
      default: tg_sel = TGw;
    endcase
  end

  // Next-state logic: tick-driven countdown, phase transitions and pre-emption.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    rem_d        = rem_q;
    phase_done_d = 1'b0;

    unique case (state_q)
      StGreen: begin
        if (emerg_act && (emerg_sel != cur_q)) begin
          // Cut the current green short without waiting for the time base.
          state_d = StYellow;
          rem_d   = YellowLoad;
        end else if (emerg_act) begin
          // Emergency road holds green: countdown frozen.
          rem_d = rem_q;
        end else if (tick) begin
          if (rem_q > 8'd1) begin
            rem_d = rem_q - 8'd1;
          end else begin
            state_d = StYellow;
            rem_d   = YellowLoad;
          end
        end
      end

      StYellow: begin
        nxt_d = nxt_eff;
        if (tick) begin
          if (rem_q > 8'd1) begin
            rem_d = rem_q - 8'd1;
          end else begin
            state_d = StAllRed;
            rem_d   = AllRedLoad;
          end
        end
      end

      StAllRed: begin
        nxt_d = nxt_eff;
        if (tick) begin
          if (rem_q > 8'd1) begin
            rem_d = rem_q - 8'd1;
          end else begin
            state_d      = StGreen;
            cur_d        = nxt_eff;
            nxt_d        = nxt_eff + 2'd1;
            rem_d        = clamp_green(tg_sel);
            phase_done_d = 1'b1;
          end
        end
      end

      default: begin
        // Unreachable encoding: fall back to a safe clearance interval.
        state_d = StAllRed;
        rem_d   = AllRedLoad;
      end
    endcase
  end

  // Lamp decode from the next state so lamps change on the same edge as the state.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lights_d[i] = LampRed;
    end
    unique case (state_d)
      StGreen:  lights_d[cur_d] = LampGreen;
      StYellow: lights_d[cur_d] = LampYellow;
      default:  lights_d[cur_d] = LampRed;
    endcase
  end

  // State and output registers; reset parks in ALL_RED so north is served first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StAllRed;
      cur_q        <= 2'd3;
      nxt_q        <= 2'd0;
      rem_q        <= AllRedLoad;
      phase_done_q <= 1'b0;
      lights_q     <= {4{LampRed}};
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      rem_q        <= rem_d;
      phase_done_q <= phase_done_d;
      lights_q     <= lights_d;
    end
  end

  assign next_road    = nxt_q;
  assign current_road = cur_q;
  assign remaining    = rem_q;
  assign phase_done   = phase_done_q;
  assign light_n      = lights_q[0];
  assign light_e      = lights_q[1];
  assign light_s      = lights_q[2];
  assign light_w      = lights_q[3];

endmodule

// File: tb/tb_signal_phase_sequencer.sv
// Bench for signal_phase_sequencer: directed opening sequence, then randomized ticks,
// green times and asynchronous resets, compared against a timeline model.
module tb_signal_phase_sequencer;

  localparam int YT   = 3;
  localparam int ART  = 1;
  localparam int MING = 5;
  localparam int MAXG = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] tg [4];
  logic [1:0] next_road, current_road;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [7:0] remaining;
  logic       phase_done;
  logic [2:0] lt [4];

  int n_total = 0;
  int n_pass  = 0;

  // Model: road being served, segment (0 green, 1 yellow, 2 all-red),
  // ticks elapsed in segment and segment length.
  int m_cur, m_seg, m_el, m_dur;
  bit m_pd;

  signal_phase_sequencer #(
    .YELLOW_T (YT),
    .ALL_RED_T(ART),
    .MIN_GREEN(MING),
    .MAX_GREEN(MAXG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .TGn         (tg[0]),
    .TGe         (tg[1]),
    .TGs         (tg[2]),
    .TGw         (tg[3]),
    .next_road   (next_road),
    .current_road(current_road),
    .light_n     (light_n),
    .light_e     (light_e),
    .light_s     (light_s),
    .light_w     (light_w),
    .remaining   (remaining),
    .phase_done  (phase_done)
  );

  assign lt[0] = light_n;
  assign lt[1] = light_e;
  assign lt[2] = light_s;
  assign lt[3] = light_w;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int clampg(input int v);
    if (v < MING) return MING;
    if (v > MAXG) return MAXG;
    return v;
  endfunction

  function automatic logic [7:0] pick_tg();
    case ($urandom_range(0, 9))
      0:       return 8'd0;
      1:       return 8'd4;
      2:       return 8'd5;
      3:       return 8'd6;
      4:       return 8'd59;
      5:       return 8'd60;
      6:       return 8'd61;
      7:       return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic model_reset();
    m_cur = 3;
    m_seg = 2;
    m_el  = 0;
    m_dur = ART;
    m_pd  = 1'b0;
  endtask

  task automatic model_step();
    m_pd = 1'b0;
    if (tick) begin
      m_el++;
      if (m_el == m_dur) begin
        m_el = 0;
        case (m_seg)
          0: begin m_seg = 1; m_dur = YT;  end
          1: begin m_seg = 2; m_dur = ART; end
          default: begin
            m_cur = (m_cur + 1) % 4;
            m_seg = 0;
            m_dur = clampg(int'(tg[m_cur]));
            m_pd  = 1'b1;
          end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    int nonred;
    int exp_lamp;
    nonred = 0;
    check("current_road", int'(current_road), m_cur);
    check("next_road", int'(next_road), (m_cur + 1) % 4);
    check("remaining", int'(remaining), m_dur - m_el);
    check("phase_done", int'(phase_done), int'(m_pd));
    for (int r = 0; r < 4; r++) begin
      exp_lamp = 4;
      if (r == m_cur && m_seg == 0) exp_lamp = 1;
      if (r == m_cur && m_seg == 1) exp_lamp = 2;
      check($sformatf("light%0d", r), int'(lt[r]), exp_lamp);
      if (lt[r] != 3'b100) nonred++;
    end
    check("one_lamp", int'(nonred <= 1), 1);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (reset) model_step();
    #2;
    compare_all();
  endtask

  // Assert reset away from the clock edge and check it takes effect at once.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_rem", int'(remaining), 1);
    check("rst_lamp_e", int'(light_e), 4);
    @(posedge clk);
    #2;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    tg    = '{8'd10, 8'd20, 8'd0, 8'd200};
    model_reset();
    #12;
    compare_all();
    reset = 1'b1;

    // Directed: tick every cycle; N=10, E=20, S=0 (clamp to 5), W=200 (clamp to 60).
    tick = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      run_cycle();
      if (k == 1) begin
        check("first_green_n", int'(light_n), 1);
        check("first_green_rem", int'(remaining), 10);
        check("first_green_pd", int'(phase_done), 1);
      end
      if (k == 2) check("pd_one_cycle", int'(phase_done), 0);
      if (k == 15) begin
        check("east_green", int'(light_e), 1);
        check("east_rem", int'(remaining), 20);
        check("east_next", int'(next_road), 2);
      end
      if (k == 39) check("south_min_clamp", int'(remaining), 5);
      if (k == 48) check("west_max_clamp", int'(remaining), 60);
      if (k == 112) check("north_again", int'(light_n), 1);
    end

    // Directed: tick once per 4 clocks with TGn=6; mid-rotation reset.
    do_reset();
    tg[0] = 8'd6;
    for (int k = 0; k < 200; k++) begin
      tick = (k % 4 == 3);
      run_cycle();
    end
    do_reset();

    // Random: sparse/dense ticks, changing green times, occasional resets.
    for (int k = 0; k < 4000; k++) begin
      tick = ($urandom_range(0, 3) != 0);
      if ((k / 500) % 2 == 1) tick = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) tg[$urandom_range(0, 3)] = pick_tg();
      if ($urandom_range(0, 299) == 0) do_reset();
      else run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
